uart_rx_fifo: RTL

- Parametrised UART receiver with a built-in receive FIFO, replacing the fixed 8N1 receive path of the calculator top level.
- Oversamples RX and supports configurable data bits, parity and stop bits.
- Buffers received words so the ALU/command FSM can consume operands and operators (e.g. "2", "-", "1", CR) at its own pace.
- Sits between the RX pin and the command-parsing FSM.

---
 rtl/uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (configurable data/parity/stop) feeding a FWFT receive FIFO.
// Latency: word visible on DOUT two CLK cycles after the final stop-bit sample.
// Backpressure: none on RX; a good frame arriving while FULL (no pop) is dropped and flags OVERRUN.
// Optional: define UART_RX_BREAK_DETECT_EN to report an all-zero frame as a one-cycle BREAK pulse.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 163,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RX,
  input  logic                          RD_EN,
  input  logic                          CLR_ERR,
  output logic [DATA_BITS-1:0]          DOUT,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          PARITY_ERR,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN,
  output logic                          BREAK,
  output logic [2:0]                    STATE
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]          samp_cnt_q, samp_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_bad_q, par_bad_d;
  logic                   push_q, push_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                   perr_set, ferr_set;
  logic                   tick, sample, exp_par;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   do_pop, do_push, ovr_set;

`ifdef UART_RX_BREAK_DETECT_EN
  logic                   par_bit_q, par_bit_d;
  logic                   brk_q, brk_d;
  logic                   brk_cond;
  // A break is a frame that is low from the start bit through the first stop bit.
  assign brk_cond = (shreg_q == '0) && ((PARITY == 0) || !par_bit_q) && (bit_cnt_q == '0);
`endif

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign sample  = tick && (samp_cnt_q == SAMP_MID);
  // Parity bit value that makes the frame correct: even -> XOR of data, odd -> its inverse.
  assign exp_par = (PARITY == 1) ? ~(^shreg_q) : (^shreg_q);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, bit timing, shift register and error-set events.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d = samp_cnt_q;
    if (tick) samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    push_d     = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    par_bit_d  = par_bit_q;
    brk_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          par_bit_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (sample) state_d = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
`ifdef UART_RX_BREAK_DETECT_EN
          par_bit_d = rx_sync_q;
`endif
          if (rx_sync_q != exp_par) begin
            par_bad_d = 1'b1;
            perr_set  = 1'b1;
          end
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!rx_sync_q) begin
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk_cond) brk_d = 1'b1;
            else          ferr_set = 1'b1;
`else
            ferr_set = 1'b1;
`endif
            state_d = S_WAIT_HIGH;
          end else if (bit_cnt_q == STOP_LAST) begin
            push_d  = !par_bad_q;
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver datapath registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_bad_q  <= par_bad_d;
      push_q     <= push_d;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  // Break pulse and captured parity sample.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      par_bit_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      brk_q     <= brk_d;
    end
  end
  assign BREAK = brk_q;
`else
  assign BREAK = 1'b0;
`endif

  // FIFO control: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    do_pop   = RD_EN && (cnt_q != '0);
    do_push  = push_q && ((cnt_q != DEPTH_C) || do_pop);
    ovr_set  = push_q && (cnt_q == DEPTH_C) && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    // Sticky flags: a set in the same cycle as CLR_ERR keeps the flag high.
    perr_d   = perr_set || (perr_q && !CLR_ERR);
    ferr_d   = ferr_set || (ferr_q && !CLR_ERR);
    ovr_d    = ovr_set  || (ovr_q  && !CLR_ERR);
  end

  // FIFO pointers, occupancy and error flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage array; the shift register still holds the frame on the push cycle.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q] <= shreg_q;
  end

  assign DOUT       = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
  assign EMPTY      = (cnt_q == '0);
  assign FULL       = (cnt_q == DEPTH_C);
  assign COUNT      = cnt_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERRUN    = ovr_q;
  assign STATE      = state_q;

endmodule
